// File: rtl/biriscv_issue_fifo.sv
// Dual-slot in-order issue queue: up to two decoded instructions enter and up to
// two leave per cycle, with flush on pipeline redirect and no enqueue bypass.
module biriscv_issue_fifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,

    input  logic        in0_valid_i,
    input  logic [31:0] in0_instr_i,
    input  logic [31:0] in0_pc_i,
    input  logic [10:0] in0_flags_i,
    input  logic        in1_valid_i,
    input  logic [31:0] in1_instr_i,
    input  logic [31:0] in1_pc_i,
    input  logic [10:0] in1_flags_i,
    output logic        in0_accept_o,
    output logic        in1_accept_o,

    output logic        out0_valid_o,
    output logic [31:0] out0_instr_o,
    output logic [31:0] out0_pc_o,
    output logic [10:0] out0_flags_o,
    input  logic        out0_accept_i,
    output logic        out1_valid_o,
    output logic [31:0] out1_instr_o,
    output logic [31:0] out1_pc_o,
    output logic [10:0] out1_flags_o,
    input  logic        out1_accept_i,

    output logic [DEPTH_W:0] level_o
);

    localparam int ENTRY_W = 75;
    localparam int CNT_W   = DEPTH_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [DEPTH_W-1:0] r_rd_ptr;
    logic [DEPTH_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_enq0;
    logic               w_enq1;
    logic               w_deq0;
    logic               w_deq1;
    logic [CNT_W-1:0]   w_enq_n;
    logic [CNT_W-1:0]   w_deq_n;
    logic [DEPTH_W-1:0] w_rd_ptr1;
    logic [DEPTH_W-1:0] w_wr_ptr1;
    logic [ENTRY_W-1:0] w_out0;
    logic [ENTRY_W-1:0] w_out1;

    // Free space is judged on the registered count only, so a same-cycle pop never frees room.
    assign in0_accept_o = !flush_i && (r_count <= CNT_W'(DEPTH - 1));
    assign in1_accept_o = !flush_i && (r_count <= CNT_W'(DEPTH - 2));

    assign out0_valid_o = (r_count >= CNT_W'(1));
    assign out1_valid_o = (r_count >= CNT_W'(2));

    assign w_enq0 = in0_valid_i && in0_accept_o;
    assign w_enq1 = w_enq0 && in1_valid_i && in1_accept_o;
    assign w_deq0 = out0_valid_o && out0_accept_i;
    assign w_deq1 = w_deq0 && out1_valid_o && out1_accept_i;

    assign w_rd_ptr1 = r_rd_ptr + DEPTH_W'(1);
    assign w_wr_ptr1 = r_wr_ptr + DEPTH_W'(1);

    assign w_out0 = r_mem[r_rd_ptr];
    assign w_out1 = r_mem[w_rd_ptr1];

    assign {out0_instr_o, out0_pc_o, out0_flags_o} = w_out0;
    assign {out1_instr_o, out1_pc_o, out1_flags_o} = w_out1;

    assign level_o = r_count;

    // Translate the per-slot handshakes into entry counts for this cycle.
    always_comb begin
        w_enq_n = CNT_W'(0);
        w_deq_n = CNT_W'(0);
        if (w_enq1) begin
            w_enq_n = CNT_W'(2);
        end else if (w_enq0) begin
            w_enq_n = CNT_W'(1);
        end else begin
            w_enq_n = CNT_W'(0);
        end
        if (w_deq1) begin
            w_deq_n = CNT_W'(2);
        end else if (w_deq0) begin
            w_deq_n = CNT_W'(1);
        end else begin
            w_deq_n = CNT_W'(0);
        end
    end

    // Storage, pointers and occupancy; flush drops both enqueues and dequeues.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq0) begin
                r_mem[r_wr_ptr] <= {in0_instr_i, in0_pc_i, in0_flags_i};
            end
            if (w_enq1) begin
                r_mem[w_wr_ptr1] <= {in1_instr_i, in1_pc_i, in1_flags_i};
            end
            r_wr_ptr <= r_wr_ptr + w_enq_n[DEPTH_W-1:0];
            r_rd_ptr <= r_rd_ptr + w_deq_n[DEPTH_W-1:0];
            r_count  <= r_count + w_enq_n - w_deq_n;
        end
    end

endmodule

// File: tb/tb_biriscv_issue_fifo.sv
// Bench for biriscv_issue_fifo: directed vector table, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_biriscv_issue_fifo;

    localparam int DEPTH   = 4;
    localparam int DEPTH_W = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in0_valid = 1'b0, in1_valid = 1'b0;
    logic [31:0] in0_instr = 32'd0, in0_pc = 32'd0, in1_instr = 32'd0, in1_pc = 32'd0;
    logic [10:0] in0_flags = 11'd0, in1_flags = 11'd0;
    logic        in0_accept, in1_accept;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_instr, out0_pc, out1_instr, out1_pc;
    logic [10:0] out0_flags, out1_flags;
    logic        out0_accept = 1'b0, out1_accept = 1'b0;
    logic [DEPTH_W:0] level;

    biriscv_issue_fifo #(.DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
        .in0_valid_i(in0_valid), .in0_instr_i(in0_instr), .in0_pc_i(in0_pc), .in0_flags_i(in0_flags),
        .in1_valid_i(in1_valid), .in1_instr_i(in1_instr), .in1_pc_i(in1_pc), .in1_flags_i(in1_flags),
        .in0_accept_o(in0_accept), .in1_accept_o(in1_accept),
        .out0_valid_o(out0_valid), .out0_instr_o(out0_instr), .out0_pc_o(out0_pc),
        .out0_flags_o(out0_flags), .out0_accept_i(out0_accept),
        .out1_valid_o(out1_valid), .out1_instr_o(out1_instr), .out1_pc_o(out1_pc),
        .out1_flags_o(out1_flags), .out1_accept_i(out1_accept),
        .level_o(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [10:0] flags;
    } entry_t;

    typedef struct {
        logic        fl, v0, v1, oa0, oa1;
        logic [31:0] pc0, pc1;
        logic        e_acc0, e_acc1, e_ov0, e_ov1;
        logic [2:0]  e_lvl;
        logic [31:0] e_opc0, e_opc1;
    } vec_t;

    entry_t q[$];
    vec_t   tbl[13];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, leaving time for outputs to settle.
    task automatic apply(input logic fl, v0, v1, input logic [31:0] pc0, pc1, input logic oa0, oa1);
        @(negedge clk);
        flush = fl; in0_valid = v0; in1_valid = v1;
        in0_pc = pc0; in1_pc = pc1;
        in0_instr = $urandom; in1_instr = $urandom;
        in0_flags = 11'($urandom); in1_flags = 11'($urandom);
        out0_accept = oa0; out1_accept = oa1;
        #1;
    endtask

    task automatic check_model();
        int sz;
        sz = q.size();
        chk("acc0", {31'd0, in0_accept}, {31'd0, (!flush && (DEPTH - sz >= 1))});
        chk("acc1", {31'd0, in1_accept}, {31'd0, (!flush && (DEPTH - sz >= 2))});
        chk("ov0", {31'd0, out0_valid}, {31'd0, (sz >= 1)});
        chk("ov1", {31'd0, out1_valid}, {31'd0, (sz >= 2)});
        chk("level", {29'd0, level}, 32'(sz));
        if (sz >= 1) begin
            chk("out0_pc", out0_pc, q[0].pc);
            chk("out0_instr", out0_instr, q[0].instr);
            chk("out0_flags", {21'd0, out0_flags}, {21'd0, q[0].flags});
        end
        if (sz >= 2) begin
            chk("out1_pc", out1_pc, q[1].pc);
            chk("out1_instr", out1_instr, q[1].instr);
            chk("out1_flags", {21'd0, out1_flags}, {21'd0, q[1].flags});
        end
    endtask

    // Model advance for the edge that follows the current inputs.
    task automatic commit();
        int  sz;
        int  ndeq;
        logic a0, a1;
        sz = q.size();
        a0 = !flush && (DEPTH - sz >= 1);
        a1 = !flush && (DEPTH - sz >= 2);
        if (flush) begin
            q.delete();
        end else begin
            ndeq = 0;
            if (sz >= 1 && out0_accept) ndeq = 1;
            if (ndeq == 1 && sz >= 2 && out1_accept) ndeq = 2;
            for (int k = 0; k < ndeq; k++) void'(q.pop_front());
            if (in0_valid && a0) begin
                q.push_back('{in0_instr, in0_pc, in0_flags});
                if (in1_valid && a1) q.push_back('{in1_instr, in1_pc, in1_flags});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        out0_accept = 1'b0; out1_accept = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          emerged;

        // fl v0 v1 oa0 oa1 pc0 pc1 | acc0 acc1 ov0 ov1 lvl opc0 opc1
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h100,32'h104, 1'b1,1'b1,1'b0,1'b0,3'd0,32'h0,  32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,  32'h0,   1'b1,1'b1,1'b1,1'b1,3'd2,32'h100,32'h104};
        tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h108,32'h10C, 1'b1,1'b1,1'b1,1'b1,3'd2,32'h100,32'h104};
        tbl[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h110,32'h114, 1'b0,1'b0,1'b1,1'b1,3'd4,32'h100,32'h104};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'h0,  32'h0,   1'b0,1'b0,1'b1,1'b1,3'd4,32'h100,32'h104};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,32'h118,32'h11C, 1'b1,1'b0,1'b1,1'b1,3'd3,32'h104,32'h108};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,   1'b0,1'b0,1'b1,1'b1,3'd4,32'h104,32'h108};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'h120,32'h0,   1'b0,1'b0,1'b1,1'b1,3'd4,32'h104,32'h108};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,   1'b1,1'b1,1'b0,1'b0,3'd0,32'h0,  32'h0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,32'h0,  32'h124, 1'b1,1'b1,1'b0,1'b0,3'd0,32'h0,  32'h0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h128,32'h0,   1'b1,1'b1,1'b0,1'b0,3'd0,32'h0,  32'h0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,32'h0,  32'h0,   1'b1,1'b1,1'b1,1'b0,3'd1,32'h128,32'h0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,  32'h0,   1'b1,1'b1,1'b0,1'b0,3'd0,32'h0,  32'h0};

        // Reset state, including zeroed data outputs.
        #2;
        chk("rst_ov0", {31'd0, out0_valid}, 32'd0);
        chk("rst_ov1", {31'd0, out1_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_acc0", {31'd0, in0_accept}, 32'd1);
        chk("rst_acc1", {31'd0, in1_accept}, 32'd1);
        chk("rst_out0_pc", out0_pc, 32'd0);
        chk("rst_out1_instr", out1_instr, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].fl, tbl[i].v0, tbl[i].v1, tbl[i].pc0, tbl[i].pc1, tbl[i].oa0, tbl[i].oa1);
            chk($sformatf("v%0d_acc0", i), {31'd0, in0_accept}, {31'd0, tbl[i].e_acc0});
            chk($sformatf("v%0d_acc1", i), {31'd0, in1_accept}, {31'd0, tbl[i].e_acc1});
            chk($sformatf("v%0d_ov0", i), {31'd0, out0_valid}, {31'd0, tbl[i].e_ov0});
            chk($sformatf("v%0d_ov1", i), {31'd0, out1_valid}, {31'd0, tbl[i].e_ov1});
            chk($sformatf("v%0d_lvl", i), {29'd0, level}, {29'd0, tbl[i].e_lvl});
            if (tbl[i].e_ov0) chk($sformatf("v%0d_opc0", i), out0_pc, tbl[i].e_opc0);
            if (tbl[i].e_ov1) chk($sformatf("v%0d_opc1", i), out1_pc, tbl[i].e_opc1);
            check_model();
            commit();
        end

        // Streaming wrap-around: pairs in, pairs out, strict order.
        do_reset();
        exp_pc = 32'h100;
        emerged = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 10) apply(1'b0, 1'b1, 1'b1, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k), 1'b1, 1'b1);
            else        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
            if (level > 3'd2) chk("wrap_level_max", {29'd0, level}, 32'd2);
            if (out0_valid) begin
                chk("wrap_pc0", out0_pc, exp_pc);
                exp_pc += 32'd4; emerged++;
                if (out1_valid) begin
                    chk("wrap_pc1", out1_pc, exp_pc);
                    exp_pc += 32'd4; emerged++;
                end
            end
            check_model();
            commit();
        end
        chk("wrap_emerged", 32'(emerged), 32'd20);

        // Flush at count 3 with a simultaneous enqueue.
        do_reset();
        apply(1'b0, 1'b1, 1'b1, 32'h200, 32'h204, 1'b0, 1'b0); check_model(); commit();
        apply(1'b0, 1'b1, 1'b0, 32'h208, 32'h0, 1'b0, 1'b0); check_model(); commit();
        apply(1'b1, 1'b1, 1'b0, 32'h20C, 32'h0, 1'b1, 1'b0);
        chk("flush_lvl_pre", {29'd0, level}, 32'd3);
        chk("flush_acc0", {31'd0, in0_accept}, 32'd0);
        chk("flush_acc1", {31'd0, in1_accept}, 32'd0);
        commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flush_lvl_post", {29'd0, level}, 32'd0);
        chk("flush_ov0_post", {31'd0, out0_valid}, 32'd0);
        commit();

        // Asynchronous reset between edges with a full queue.
        apply(1'b0, 1'b1, 1'b1, 32'h300, 32'h304, 1'b0, 1'b0); check_model(); commit();
        apply(1'b0, 1'b1, 1'b1, 32'h308, 32'h30C, 1'b0, 1'b0); check_model(); commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("arst_lvl_pre", {29'd0, level}, 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ov0", {31'd0, out0_valid}, 32'd0);
        chk("arst_ov1", {31'd0, out1_valid}, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_out0_pc", out0_pc, 32'd0);
        chk("arst_acc1", {31'd0, in1_accept}, 32'd1);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0); check_model(); commit();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0); check_model(); commit();

        // Random traffic against the reference queue.
        for (int k = 0; k < 3000; k++) begin
            apply(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom));
            check_model();
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
